debounce_sync: RTL and testbench
================================

# debounce_sync

Single-channel switch/button conditioner for the lab board inputs. It synchronises a raw mechanical input to `clk` and debounces it with a counter-qualified state machine. It then drives a clean level plus one-cycle edge strobes. The level output feeds the `D` or `G` input of the downstream D latch stage; instantiate once per switch.

## Interface
Parameters:
- `CNT_MAX`, default 1000000: number of consecutive stable cycles, after the first differing sample, required to accept a new level. Must be ≥ 1. Counter width is $clog2(CNT_MAX+1).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `btn_in`  input  1  raw, unsynchronised switch/button level.
- `btn_out`  output  1  debounced level; drives latch `D`/`G`.
- `rise`  output  1  one-cycle pulse when `btn_out` goes 0→1.
- `fall`  output  1  one-cycle pulse when `btn_out` goes 1→0.

## Operation
- Sampled input `s`: the synchroniser output (see Configuration) or `btn_in` directly.
- FSM states: `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`.
- `STABLE_LO`: `btn_out`=0. If `s`=1, go to `WAIT_HI` and clear the counter to 0.
- `WAIT_HI`:
  - If `s`=0, return to `STABLE_LO`. No pulse.
  - Else, if counter == CNT_MAX-1, go to `STABLE_HI`, set `btn_out`=1 and `rise`=1.
  - Otherwise, increment the counter.
- `STABLE_HI` and `WAIT_LO` are mirror images of the above, using `fall`.
- Counter holds its value in the STABLE states and never wraps; it saturates at CNT_MAX-1 by construction.
- `rise` and `fall` are registered. They are asserted exactly in the cycle `btn_out` changes, for one cycle only, and are never both high.
- A glitch shorter than CNT_MAX+1 FSM samples produces no change on any output.

## Timing
- Reset values, applied asynchronously: state `STABLE_LO`, counter 0, `btn_out`=0, `rise`=0, `fall`=0, synchroniser flops 0.
- Without synchroniser: `btn_in` changes before edge e0 and stays stable. `btn_out` and the strobe update at edge e0+CNT_MAX. Latency is CNT_MAX cycles.
- With synchroniser: the same stimulus updates outputs at e0+CNT_MAX+2. Latency is CNT_MAX+2 cycles.
- Reset asserted mid-debounce aborts immediately. No strobe is emitted during or after reset until a new full qualification completes.
- `btn_in` high at reset release is treated as a fresh 0→1 change. It requires full qualification, then produces one `rise`.
- CNT_MAX=1: a new level is accepted after 2 consecutive FSM samples (enter WAIT, then accept).
- Input toggling every cycle: the FSM alternates STABLE↔WAIT. Outputs do not change.

## Configuration
- Macro `DEBOUNCE_SYNC_2FF_EN`.
- Defined: a two-flop synchroniser (`btn_in`→s1→s2) feeds the FSM with `s`=s2. This adds 2 cycles of latency. Required for real board inputs.
- Undefined: the FSM samples `btn_in` directly (`s`=`btn_in`). No synchroniser flops exist. Intended for fast simulation only.
- The FSM, counter and strobe behaviour are otherwise identical.

## Test plan
Bench settings: CNT_MAX=4, 10 ns clock, `DEBOUNCE_SYNC_2FF_EN` defined unless noted.
- Reset then hold `btn_in`=0 for 20 cycles → `btn_out`, `rise` and `fall` stay 0 throughout.
- Step `btn_in` 0→1 just before edge e0 and hold → `btn_out`=1 and `rise`=1 at edge e0+6. `rise` returns to 0 at e0+7. `fall` stays 0.
- From `btn_out`=1, apply a 3-cycle low glitch on `btn_in` → no change on `btn_out` and no `fall`. Then hold low → `fall` pulses once, 6 cycles after the final 1→0 change.
- Step `btn_in` 0→1, then assert `rst` for 1 cycle at e0+4 with `btn_in` still 1 → all outputs are 0 immediately. After release, `btn_out` rises exactly once, 6 edges after the first post-reset edge, with one `rise` pulse.
- With the macro undefined, step `btn_in` 0→1 before e0 → `btn_out`=1 and `rise`=1 at e0+4.
- Toggle `btn_in` every cycle for 50 cycles → `btn_out` is constant and no strobe occurs.

Source files
------------

// File: rtl/debounce_sync.sv
// debounce_sync: single-channel switch/button conditioner.
// Optional two-flop input synchroniser enabled by defining DEBOUNCE_SYNC_2FF_EN;
// when undefined the FSM samples btn_in directly (fast simulation only).
// A counter-qualified FSM accepts a new level only after CNT_MAX+1 consecutive
// samples of it, then drives a clean level plus one-cycle rise/fall strobes.
module debounce_sync #(
    parameter int CNT_MAX = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_out,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic          s;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          btn_out_reg;
    logic          rise_reg;
    logic          fall_reg;

`ifdef DEBOUNCE_SYNC_2FF_EN
    logic s1_reg;
    logic s2_reg;

    // Two-flop synchroniser bringing the asynchronous button into clk's domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= btn_in;
            s2_reg <= s1_reg;
        end
    end

    assign s = s2_reg;
`else
    assign s = btn_in;
`endif

    // Debounce FSM: counter qualifies a candidate level; strobes are registered
    // and only ever set in the cycle the level is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= STABLE_LO;
            cnt_reg     <= '0;
            btn_out_reg <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                STABLE_LO: begin
                    if (s) begin
                        state_reg <= WAIT_HI;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_reg <= STABLE_LO;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= STABLE_HI;
                        btn_out_reg <= 1'b1;
                        rise_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_reg <= WAIT_LO;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_reg <= STABLE_HI;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= STABLE_LO;
                        btn_out_reg <= 1'b0;
                        fall_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= STABLE_LO;
                end
            endcase
        end
    end

    assign btn_out = btn_out_reg;
    assign rise    = rise_reg;
    assign fall    = fall_reg;

endmodule

// File: tb/tb_debounce_sync.sv
// Testbench for debounce_sync (CNT_MAX=4, 10 ns clock). Works with or without
// DEBOUNCE_SYNC_2FF_EN; the reference model adds the matching input latency.
module tb_debounce_sync;

    localparam int CNT_MAX = 4;
`ifdef DEBOUNCE_SYNC_2FF_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_out;
    logic rise;
    logic fall;

    int checks;
    int failures;
    bit drive_done;

    // expected {btn_out, rise, fall} after each rising edge
    logic [2:0] exp_q[$];

    // reference model state: delayed input samples, accepted level, run length
    logic dly_q[$];
    logic m_out;
    int   m_run;

    debounce_sync #(.CNT_MAX(CNT_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_out(btn_out),
        .rise(rise),
        .fall(fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        dly_q.delete();
        for (int i = 0; i < LAT; i++) dly_q.push_back(1'b0);
        m_out = 1'b0;
        m_run = 0;
    endtask

    // Drive one cycle (inputs change on the falling edge) and predict the
    // outputs after the following rising edge.
    task automatic step(input logic b, input logic r);
        logic smp;
        logic rs;
        logic fl;
        @(negedge clk);
        btn_in = b;
        rst    = r;
        rs = 1'b0;
        fl = 1'b0;
        if (r) begin
            model_reset();
            #1;
            checks++;
            if ({btn_out, rise, fall} !== 3'b000) begin
                failures++;
                $display("FAIL rst_immediate: got out/rise/fall=%b%b%b expected 000",
                         btn_out, rise, fall);
            end
        end else begin
            if (LAT == 0) begin
                smp = b;
            end else begin
                smp = dly_q.pop_front();
                dly_q.push_back(b);
            end
            // accept a new level after CNT_MAX+1 consecutive differing samples
            if (smp != m_out) m_run++;
            else m_run = 0;
            if (m_run == CNT_MAX + 1) begin
                m_out = smp;
                rs = smp;
                fl = ~smp;
                m_run = 0;
            end
        end
        exp_q.push_back({m_out, rs, fl});
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    // Monitor: pops one expectation per rising edge and compares.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({btn_out, rise, fall} !== e) begin
                    failures++;
                    $display("FAIL outputs @%0t: got out/rise/fall=%b%b%b expected %b",
                             $time, btn_out, rise, fall, e);
                end
                checks++;
                if ((rise & fall) !== 1'b0) begin
                    failures++;
                    $display("FAIL strobes_both @%0t: got rise=%b fall=%b expected not both",
                             $time, rise, fall);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int lvl;
        int len;
        checks = 0;
        failures = 0;
        drive_done = 1'b0;
        rst = 1'b1;
        btn_in = 1'b0;
        model_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        $display("phase idle_low");
        hold(1'b0, 20);
        $display("phase step_high");
        hold(1'b1, 12);
        $display("phase glitch_low");
        hold(1'b0, 3);
        hold(1'b1, 8);
        hold(1'b0, 12);
        $display("phase reset_mid_debounce");
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b1, 12);
        $display("phase reset_while_high");
        step(1'b1, 1'b1);
        hold(1'b0, 10);
        $display("phase toggle");
        for (int i = 0; i < 50; i++) step(i[0], 1'b0);
        hold(1'b0, 10);
        $display("phase random");
        for (int i = 0; i < 150; i++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            if ($urandom_range(0, 29) == 0) step(lvl[0], 1'b1);
            hold(lvl[0], len);
        end
        hold(1'b0, 10);
        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        drive_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
